fft_bitrev_reorder: RTL
=======================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter N, default 64, FFT point count; power of two, 4 to 1024.
REQ-002 SHALL have parameter WIDTH, default 16, data bit length per real/imag component.
REQ-003 SHALL have port clock, input, 1, master clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port di_en, input, 1; di_re/di_im carry a valid sample this cycle.
REQ-006 SHALL have ports di_re and di_im, input, WIDTH each; FFT output sample in bit-reversed bin order.
REQ-007 SHALL have port do_en, output, 1; do_re/do_im/do_idx carry a valid sample this cycle.
REQ-008 SHALL have ports do_re and do_im, output, WIDTH each; FFT sample in natural bin order.
REQ-009 SHALL have port do_idx, output, log2(N); natural bin index of the current output sample.

Function
REQ-010 SHALL hold two N-entry banks of {re,im} storage (ping-pong); one bank is written while the other is read.
REQ-011 SHALL write each accepted sample (di_en=1 at a rising edge) to the write bank at address wr_cnt, then increment wr_cnt.
REQ-012 SHALL hold wr_cnt and write nothing while di_en=0; gaps inside a frame are allowed.
REQ-013 SHALL treat the write at wr_cnt=N-1 as frame-complete: wr_cnt wraps to 0, banks swap, and readout of the completed bank starts on the next cycle.
REQ-014 SHALL read output j (j=0..N-1) from address bitrev(j) over log2(N) bits, on N consecutive cycles with no gaps.
REQ-015 SHALL drive do_idx=j with the sample read from address bitrev(j).
REQ-016 SHALL set latency as follows: with the output register compiled in, output j=0 is valid in the cycle after the rising edge that follows the frame-complete edge.
REQ-017 SHALL support back-to-back frames (di_en held high indefinitely): the bank swap and the restart of rd_cnt at 0 coincide on the same edge, and do_en stays continuously high.
REQ-018 SHALL make overflow impossible by construction: a frame needs at least N input cycles and readout takes exactly N cycles.
REQ-019 SHALL transfer data unmodified: no scaling, rounding or sign change.
REQ-020 SHALL use a readout state machine with states IDLE and READ. IDLE goes to READ on frame-complete. READ goes to IDLE at rd_cnt=N-1 unless frame-complete occurs on the same edge; in that case it stays in READ and rd_cnt goes to 0.
REQ-021 SHALL drive do_re/do_im/do_idx to zero whenever do_en=0.

Reset
REQ-022 SHALL, on reset assertion, asynchronously clear wr_cnt, rd_cnt, bank select, state (to IDLE), do_en, do_re, do_im and do_idx to 0.
REQ-023 SHALL NOT clear bank contents on reset.
REQ-024 SHALL, on reset mid-frame or mid-readout, discard the partial input frame and abort readout; the first frame after reset starts at wr_cnt=0.

Configuration
REQ-025 SHALL provide macro FFT_REORDER_OUT_FF_EN.
REQ-026 SHALL, when FFT_REORDER_OUT_FF_EN is defined, register do_en/do_re/do_im/do_idx: output j=0 is valid 2 cycles after the frame-complete edge, i.e. N+1 cycles after sample 0 when input is contiguous.
REQ-027 SHALL, when FFT_REORDER_OUT_FF_EN is undefined, drive outputs combinationally from the read port and state: output j=0 is valid 1 cycle after the frame-complete edge. Interface and ordering are unchanged.

Verification
REQ-028 SHALL cover this scenario: N=64, OUT_FF on; one contiguous frame with di_re=k, di_im=-k for k=0..63. Required response: 64 contiguous do_en cycles starting 65 cycles after sample 0; do_idx=j, do_re=bitrev6(j) (j=1 gives 32, j=2 gives 16, j=63 gives 63); do_im=-do_re.
REQ-029 SHALL cover this scenario: three back-to-back frames with di_en held high, frame f data = f*64+k. Required response: do_en high for 192 consecutive cycles; frame-1 output j=0 carries value 64 immediately after frame-0 j=63.
REQ-030 SHALL cover this scenario: a frame with di_en toggling 1,0,1,0 (128 cycles). Required response: same output values as REQ-028, readout starting 2 cycles after the 64th accepted sample.
REQ-031 SHALL cover this scenario: reset asserted after 30 samples, then a full frame. Required response: do_en stays 0 until the new frame completes; output matches the new frame only.
REQ-032 SHALL cover this scenario: reset asserted at readout j=10. Required response: do_en, do_re, do_im and do_idx go to 0 immediately (asynchronously) and there is no further output until the next full frame.
REQ-033 SHALL cover this scenario: REQ-028 repeated with FFT_REORDER_OUT_FF_EN undefined. Required response: identical values, with every output one cycle earlier.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Converts a stream of FFT output samples arriving in bit-reversed bin order
// into natural bin order. Two N-entry {re,im} banks work ping-pong: one
// bank collects the incoming frame while the other is read back out in
// natural order. Input may stall (di_en low) at any point inside a frame.
// Readout of a completed frame is gap-free for N cycles, and back-to-back
// frames produce a continuous output stream.
//
// Parameters:
//   N      FFT point count (power of two, 4..1024)
//   WIDTH  bits per real/imag component
//
// Ports:
//   clock          master clock, rising edge
//   reset          asynchronous, active-high reset of all control state and
//                  outputs (bank contents are not cleared)
//   di_en          di_re/di_im hold a valid sample this cycle
//   di_re, di_im   input sample, bit-reversed bin order
//   do_en          do_re/do_im/do_idx hold a valid sample this cycle
//   do_re, do_im   output sample, natural bin order (zero when do_en=0)
//   do_idx         natural bin index of the output sample (zero when do_en=0)
//
// Build option:
//   FFT_REORDER_OUT_FF_EN  when defined, the outputs are registered, adding
//                          one cycle of latency. When undefined, the outputs
//                          are driven straight from the read port and state.
// ---------------------------------------------------------------------------
module fft_bitrev_reorder #(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 di_en,
    input  logic [WIDTH-1:0]     di_re,
    input  logic [WIDTH-1:0]     di_im,
    output logic                 do_en,
    output logic [WIDTH-1:0]     do_re,
    output logic [WIDTH-1:0]     do_im,
    output logic [$clog2(N)-1:0] do_idx
);

    localparam int AW = $clog2(N);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [AW-1:0]      wr_cnt_reg, wr_cnt_next;
    logic [AW-1:0]      rd_cnt_reg, rd_cnt_next;
    logic               bank_sel_reg, bank_sel_next;   // bank being written
    logic [0:0]         state_reg, state_next;
    logic               frame_done;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;

    // Both banks live in one array; the top address bit selects the bank.
    logic [2*WIDTH-1:0] mem [0:2*N-1];
    logic [2*WIDTH-1:0] rd_data_reg;

    assign frame_done = di_en && (wr_cnt_reg == AW'(N-1));

    always_comb begin
        wr_cnt_next   = wr_cnt_reg;
        rd_cnt_next   = rd_cnt_reg;
        bank_sel_next = bank_sel_reg;
        state_next    = state_reg;

        // N is a power of two, so the counter wraps to 0 after N-1 by itself.
        if (di_en)
            wr_cnt_next = wr_cnt_reg + AW'(1);

        if (frame_done) begin
            // A new frame may complete exactly as the previous readout ends;
            // readout then restarts at 0 with no idle cycle in between.
            bank_sel_next = ~bank_sel_reg;
            state_next    = ST_READ;
            rd_cnt_next   = '0;
        end else if (state_reg == ST_READ) begin
            if (rd_cnt_reg == AW'(N-1)) begin
                state_next  = ST_IDLE;
                rd_cnt_next = '0;
            end else begin
                rd_cnt_next = rd_cnt_reg + AW'(1);
            end
        end
    end

    // The read address is formed from the next-state counter so the RAM's
    // registered read lines up with state_reg/rd_cnt_reg in the next cycle.
    assign rd_en = (state_next == ST_READ);

    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
            assign rd_addr[gi] = rd_cnt_next[AW-1-gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt_reg   <= '0;
            rd_cnt_reg   <= '0;
            bank_sel_reg <= 1'b0;
            state_reg    <= ST_IDLE;
        end else begin
            wr_cnt_reg   <= wr_cnt_next;
            rd_cnt_reg   <= rd_cnt_next;
            bank_sel_reg <= bank_sel_next;
            state_reg    <= state_next;
        end
    end

    // Storage: no reset so it maps onto block RAM. On a frame-complete edge
    // the read bank equals the bank being written, but the write goes to
    // address N-1 while the read is of address bitrev(0)=0, so they never
    // collide.
    always_ff @(posedge clock) begin
        if (di_en && !reset)
            mem[{bank_sel_reg, wr_cnt_reg}] <= {di_re, di_im};
        if (rd_en && !reset)
            rd_data_reg <= mem[{~bank_sel_next, rd_addr}];
    end

`ifdef FFT_REORDER_OUT_FF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            do_en  <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
            do_idx <= '0;
        end else if (state_reg == ST_READ) begin
            do_en  <= 1'b1;
            do_re  <= rd_data_reg[2*WIDTH-1:WIDTH];
            do_im  <= rd_data_reg[WIDTH-1:0];
            do_idx <= rd_cnt_reg;
        end else begin
            do_en  <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
            do_idx <= '0;
        end
    end
`else
    always_comb begin
        do_en  = 1'b0;
        do_re  = '0;
        do_im  = '0;
        do_idx = '0;
        if (state_reg == ST_READ) begin
            do_en  = 1'b1;
            do_re  = rd_data_reg[2*WIDTH-1:WIDTH];
            do_im  = rd_data_reg[WIDTH-1:0];
            do_idx = rd_cnt_reg;
        end
    end
`endif

endmodule
